inst_fetch_ctrl: RTL
====================

Name: inst_fetch_ctrl

Overview:
Sequences the CPU's combinational instruction memory (16-bit word address, 32-bit data). Owns the fetch PC, fetches one word per cycle into a small prefetch queue, and hands instructions with their PC to decode over a valid/ready handshake. A taken branch or jump from execute redirects it, flushing the queue.

Parameters:
ADDR_W, 16, instruction-memory word address width; PC width.
DATA_W, 32, instruction width.
DEPTH, 4, prefetch queue entries; power of two, ≥2.
RESET_PC, 0, fetch address loaded on reset.
HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
imem_addr  out  ADDR_W  address to instruction memory = pc_reg (registered, glitch-free).
imem_data  in  DATA_W  instruction memory read data, valid in the same cycle.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  ADDR_W  new fetch address.
out_valid  out  1  head entry available to decode.
out_ready  in  1  decode accepts head entry.
out_instr  out  DATA_W  head instruction.
out_pc  out  ADDR_W  address of head instruction.
fill_count  out  clog2(DEPTH)+1  entries currently queued.

Behaviour:
- Reset, asynchronous, at any time including mid-operation:
  - pc_reg=RESET_PC; queue pointers and count = 0.
  - out_valid=0, out_instr=0, out_pc=0, fill_count=0.
- Queue: circular buffer of {pc, instr}, registered storage, read pointer and write pointer.
  - out_valid = (count != 0).
  - out_instr and out_pc come from the head entry when out_valid=1; both are forced to 0 when out_valid=0.
- Pop: occurs when out_valid & out_ready.
- Push (fetch): occurs when there is no redirect and (count < DEPTH or a pop happens this cycle).
  - Writes {pc_reg, imem_data}.
  - pc_reg <= pc_reg + 1, modulo 2^ADDR_W; 16'hFFFF wraps to 0.
  - If no push occurs, pc_reg holds.
- Simultaneous push and pop: count is unchanged. A full queue keeps streaming at one instruction per cycle.
- Latency:
  - First instruction after reset release: pushed in cycle 0, out_valid=1 in cycle 1.
  - Steady state: one instruction per cycle while out_ready=1.
- Redirect has highest priority. In a redirect cycle:
  - A pop handshake in the same cycle completes; that instruction is delivered.
  - All remaining entries are discarded; count <= 0.
  - No push occurs.
  - pc_reg <= redirect_pc.
  - Next cycle: redirect_pc is pushed; out_valid rises the cycle after that. Redirect-to-valid is 2 cycles.
- Back-to-back redirects: the last one wins. Each redirect flushes and reloads pc_reg.
- out_ready=0 with a full queue: no fetch; imem_addr is stable; head entry is held with no change.
- fill_count always equals the number of valid entries (0..DEPTH).

Optional Feature:
Macro: INST_FETCH_HALT_DETECT_EN.
- Defined:
  - Extra output port halted (1 bit, reset 0).
  - When a pushed word equals HALT_WORD, halted <= 1; that word is still enqueued.
  - While halted=1, no further pushes occur; pc_reg holds at the address after the halt word.
  - A redirect clears halted in the same edge and fetch resumes from redirect_pc.
  - Reset clears halted.
- Not defined: HALT_WORD is ignored, there is no halted port, and fetch never self-stops.

Test Plan:
1. Reset release, memory[n]=n+100, out_ready=1 → out_valid rises at cycle 1; out_pc=0,1,2,3… and out_instr=100,101,102… one per cycle, no gaps.
2. out_ready=0 for 10 cycles after reset → fill_count reaches 4 and holds; imem_addr=4 stable. Then out_ready=1 → PCs 0..7 delivered with no gap or duplicate.
3. Queue holds PCs 5..8; assert redirect_valid with redirect_pc=16'h0040 and out_ready=1 → PC 5 is delivered that cycle, PCs 6..8 are never seen, out_valid=0 for one cycle, then out_pc=0x0040.
4. Redirect to 16'hFFFE → PCs 0xFFFE, 0xFFFF, 0x0000, 0x0001 are delivered in order.
5. Assert rst asynchronously mid-stream (between edges) with a full queue → out_valid, fill_count, out_pc and out_instr drop to 0 immediately; after release, fetch restarts at RESET_PC.
6. INST_FETCH_HALT_DETECT_EN defined, memory[3]=HALT_WORD → PCs 0..3 delivered, halted=1, imem_addr stays 4, no further out_valid. A redirect to 0x10 then clears halted and delivers PC 0x10.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, prefetches one word per cycle
// into a circular queue and hands {pc, instr} to decode. Optional halt detection: INST_FETCH_HALT_DETECT_EN.
module inst_fetch_ctrl #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]        out_pc,
`ifdef INST_FETCH_HALT_DETECT_EN
  output logic                     halted,
`endif
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a transfer to decode happens on a rising edge where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || $bits(HALT_WORD) != DATA_W) begin : g_param_check
    $error("inst_fetch_ctrl: DEPTH must be a power of two >= 2");
  end

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              pop;
  logic              push;
  logic              fetch_en;

`ifdef INST_FETCH_HALT_DETECT_EN
  logic halt_r;

  assign fetch_en = ~halt_r;
  assign halted   = halt_r;

  // The halt word itself is still enqueued; only later fetches are blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_r <= 1'b0;
    end else if (redirect_valid) begin
      halt_r <= 1'b0;
    end else if (push && imem_data == HALT_WORD) begin
      halt_r <= 1'b1;
    end
  end
`else
  assign fetch_en = 1'b1;
`endif

  assign imem_addr  = pc_reg;
  assign fill_count = count;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign push       = ~redirect_valid & fetch_en & ((count < CNT_W'(DEPTH)) | pop);
  assign out_instr  = out_valid ? instr_q[rd_ptr] : '0;
  assign out_pc     = out_valid ? pc_q[rd_ptr]    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      // Flush: any pop this cycle has already been delivered to decode.
      pc_reg <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_reg <= pc_reg + ADDR_W'(1);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= pc_reg;
      instr_q[wr_ptr] <= imem_data;
    end
  end

endmodule
